// File: rtl/axis_adder_arbiter_pkg.sv
// Shared types and helpers for the axis_adder_arbiter block.
// Holds the scheduler state enum, a ceiling-log2 helper and the
// operand-slice offsets used to split a requester's tdata into a/b.
package axis_adder_arbiter_pkg;

    // Scheduler state: IDLE arbitrates, GRANT streams one packet.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Operand a sits at the bottom of each per-port slice.
    localparam int unsigned A_LSB = 0;

    // Ceiling log2, minimum 1 so index vectors never collapse to zero width.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = (n > 0) ? n - 1 : 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    // Operand b sits directly above a, so its offset equals the operand width.
    function automatic int unsigned b_lsb(input int unsigned c_width);
        return c_width;
    endfunction

endpackage

// File: rtl/axis_adder_arbiter_if.sv
// Bundle of the requester-side and result-side AXI4-Stream signals.
//   s_axis_*  : PORTS requesters, operands packed {b,a} per port
//   m_axis_*  : single tagged result stream (sum, tlast, tid)
//   busy      : scheduler is serving a packet
// Modports: slave = the arbiter's view, master = the surrounding logic.
interface axis_adder_arbiter_if #(
    parameter int unsigned PORTS    = 4,
    parameter int unsigned c_WIDTH  = 4,
    parameter int unsigned ID_WIDTH = 2
);
    logic [PORTS*2*c_WIDTH-1:0] s_axis_tdata;
    logic [PORTS-1:0]           s_axis_tvalid;
    logic [PORTS-1:0]           s_axis_tready;
    logic [PORTS-1:0]           s_axis_tlast;
    logic [c_WIDTH:0]           m_axis_tdata;
    logic                       m_axis_tvalid;
    logic                       m_axis_tready;
    logic                       m_axis_tlast;
    logic [ID_WIDTH-1:0]        m_axis_tid;
    logic                       busy;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output m_axis_tid, busy
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tid, busy
    );
endinterface

// File: rtl/axis_adder_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req         : per-port request vector
//   last_grant  : most recently served port; search starts one above it
//   grant_idx   : first requesting port found walking upward with wrap
//   grant_valid : at least one port is requesting
module rr_arbiter
    import axis_adder_arbiter_pkg::*;
#(
    parameter  int unsigned PORTS = 4,
    localparam int unsigned IDX_W = clog2(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int off = int'(PORTS); off >= 1; off--) begin
            if (req[IDX_W'((int'(last_grant) + off) % int'(PORTS))]) begin
                grant_idx   = IDX_W'((int'(last_grant) + off) % int'(PORTS));
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_adder_arbiter.sv
// Packet-level round-robin scheduler in front of one registered adder.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : axis_adder_arbiter_if.slave
//          s_axis_* in  : PORTS operand streams ({b,a} per port)
//          s_axis_tready: one-hot (or zero) towards the granted port
//          m_axis_*     : registered sum, tlast copy and granted-port tag
//          busy         : high while a packet owns the adder
// One port owns the adder from its first beat to its tlast beat; an
// arbitration cycle in IDLE separates consecutive packets.
module axis_adder_arbiter
    import axis_adder_arbiter_pkg::*;
#(
    parameter int unsigned PORTS    = 4,
    parameter int unsigned c_WIDTH  = 4,
    parameter int unsigned ID_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    axis_adder_arbiter_if.slave  bus
);

    localparam int unsigned IDX_W = clog2(PORTS);
    localparam int unsigned OP_W  = 2 * c_WIDTH;
    localparam int unsigned SUM_W = c_WIDTH + 1;
    localparam int unsigned B_LSB = b_lsb(c_WIDTH);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;

    logic [c_WIDTH-1:0] a_arr [PORTS];
    logic [c_WIDTH-1:0] b_arr [PORTS];
    logic [c_WIDTH-1:0] sel_a_c, sel_b_c;
    logic               sel_valid_c, sel_last_c;
    logic               out_free_c, beat_c;
    logic [PORTS-1:0]   ready_c;

    logic [SUM_W-1:0]    m_data_q;
    logic                m_valid_q;
    logic                m_last_q;
    logic [ID_WIDTH-1:0] m_tid_q;

    // Split each port's tdata into its a/b operands.
    for (genvar i = 0; i < int'(PORTS); i++) begin : g_slice
        assign a_arr[i] = bus.s_axis_tdata[i*OP_W + A_LSB +: c_WIDTH];
        assign b_arr[i] = bus.s_axis_tdata[i*OP_W + B_LSB +: c_WIDTH];
    end

    // Mux the granted port's beat onto the adder inputs.
    assign sel_a_c     = a_arr[grant_q];
    assign sel_b_c     = b_arr[grant_q];
    assign sel_valid_c = bus.s_axis_tvalid[grant_q];
    assign sel_last_c  = bus.s_axis_tlast[grant_q];

    // Output slot can take a beat if empty or being drained this cycle.
    assign out_free_c = !m_valid_q || bus.m_axis_tready;

    rr_arbiter #(
        .PORTS (PORTS)
    ) u_rr_arbiter (
        .req         (bus.s_axis_tvalid),
        .last_grant  (last_grant_q),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    // Next-state, grant bookkeeping and per-port ready.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        ready_c      = '0;
        beat_c       = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                ready_c[grant_q] = out_free_c;
                beat_c           = sel_valid_c && out_free_c;
                // Grant is held until the owner's tlast beat is taken.
                if (beat_c && sel_last_c) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Scheduler state register; port 0 is first in line after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(PORTS - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Result register: load on an accepted beat, otherwise drain when taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_tid_q   <= '0;
        end else if (beat_c) begin
            m_data_q  <= SUM_W'(sel_a_c) + SUM_W'(sel_b_c);
            m_valid_q <= 1'b1;
            m_last_q  <= sel_last_c;
            m_tid_q   <= ID_WIDTH'(grant_q);
        end else if (bus.m_axis_tready) begin
            m_valid_q <= 1'b0;
        end
    end

    assign bus.s_axis_tready = ready_c;
    assign bus.m_axis_tdata  = m_data_q;
    assign bus.m_axis_tvalid = m_valid_q;
    assign bus.m_axis_tlast  = m_last_q;
    assign bus.m_axis_tid    = m_tid_q;
    assign bus.busy          = (state_q == GRANT);

endmodule

// File: tb/tb_axis_adder_arbiter.sv
// Self-checking bench for axis_adder_arbiter: directed scenarios plus a
// randomized run compared cycle by cycle against a packet-level model.
module tb_axis_adder_arbiter;

    localparam int P  = 4;
    localparam int W  = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axis_adder_arbiter_if #(.PORTS(P), .c_WIDTH(W), .ID_WIDTH(IW)) bus ();

    axis_adder_arbiter #(.PORTS(P), .c_WIDTH(W), .ID_WIDTH(IW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [W-1:0] drv_a [P];
    logic [W-1:0] drv_b [P];
    logic [P-1:0] drv_valid  = '0;
    logic [P-1:0] drv_last   = '0;
    logic         drv_mready = 1'b1;

    for (genvar i = 0; i < P; i++) begin : g_drv
        assign bus.s_axis_tdata[i*2*W +: W]     = drv_a[i];
        assign bus.s_axis_tdata[i*2*W + W +: W] = drv_b[i];
    end
    assign bus.s_axis_tvalid = drv_valid;
    assign bus.s_axis_tlast  = drv_last;
    assign bus.m_axis_tready = drv_mready;

    int total = 0;
    int bad   = 0;

    // Packet-level model: owner (-1 when arbitrating), last served port, output slot.
    int mo_owner, mo_last, mo_od, mo_ol, mo_oid;
    bit mo_ov;

    task automatic model_reset();
        mo_owner = -1; mo_last = P - 1;
        mo_ov = 1'b0; mo_od = 0; mo_ol = 0; mo_oid = 0;
    endtask

    function automatic logic [P-1:0] model_ready();
        logic [P-1:0] r;
        r = '0;
        if (mo_owner >= 0 && (!mo_ov || drv_mready)) r = P'(1) << mo_owner;
        return r;
    endfunction

    task automatic model_step();
        logic [P-1:0] rdy;
        rdy = model_ready();
        if (mo_owner < 0) begin
            if (drv_mready) mo_ov = 1'b0;
            for (int k = 1; k <= P; k++) begin
                int p;
                p = (mo_last + k) % P;
                if (drv_valid[p]) begin
                    mo_owner = p;
                    break;
                end
            end
        end else if (rdy[mo_owner] && drv_valid[mo_owner]) begin
            mo_ov  = 1'b1;
            mo_od  = int'(drv_a[mo_owner]) + int'(drv_b[mo_owner]);
            mo_ol  = int'(drv_last[mo_owner]);
            mo_oid = mo_owner;
            if (drv_last[mo_owner]) begin
                mo_last  = mo_owner;
                mo_owner = -1;
            end
        end else if (drv_mready) begin
            mo_ov = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic drive_port(input int p, input logic v, input int a, input int b, input logic l);
        drv_valid[p] = v;
        drv_a[p]     = W'(a);
        drv_b[p]     = W'(b);
        drv_last[p]  = l;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", bus.m_axis_tvalid); end
        total++; if (bus.m_axis_tdata !== 5'd0) begin bad++; $display("FAIL reset_data: got %0d want 0", bus.m_axis_tdata); end
        total++; if (bus.m_axis_tid !== 2'd0) begin bad++; $display("FAIL reset_tid: got %0d want 0", bus.m_axis_tid); end
        total++; if (bus.m_axis_tlast !== 1'b0) begin bad++; $display("FAIL reset_last: got %0b want 0", bus.m_axis_tlast); end
        total++; if (bus.s_axis_tready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", bus.s_axis_tready); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
        rst = 1'b0;
        tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %0b want 0", bus.busy); end
    endtask

    task automatic test_single_beat();
        drive_port(0, 1'b1, 3, 5, 1'b1);
        #1;
        total++; if (bus.s_axis_tready !== 4'b0000) begin bad++; $display("FAIL single_idle_ready: got %b want 0000", bus.s_axis_tready); end
        tick();
        total++; if (bus.s_axis_tready !== 4'b0001) begin bad++; $display("FAIL single_grant_ready: got %b want 0001", bus.s_axis_tready); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %0b want 1", bus.busy); end
        total++; if (bus.m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL single_early_valid: got %0b want 0", bus.m_axis_tvalid); end
        tick();
        drive_port(0, 1'b0, 0, 0, 1'b0);
        #1;
        total++; if (bus.m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL single_valid: got %0b want 1", bus.m_axis_tvalid); end
        total++; if (bus.m_axis_tdata !== 5'd8) begin bad++; $display("FAIL single_data: got %0d want 8", bus.m_axis_tdata); end
        total++; if (bus.m_axis_tid !== 2'd0) begin bad++; $display("FAIL single_tid: got %0d want 0", bus.m_axis_tid); end
        total++; if (bus.m_axis_tlast !== 1'b1) begin bad++; $display("FAIL single_last: got %0b want 1", bus.m_axis_tlast); end
        total++; if (bus.s_axis_tready !== 4'b0000) begin bad++; $display("FAIL single_after_ready: got %b want 0000", bus.s_axis_tready); end
        tick();
        total++; if (bus.m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL single_drain: got %0b want 0", bus.m_axis_tvalid); end
    endtask

    task automatic test_carry();
        drive_port(2, 1'b1, 15, 15, 1'b1);
        tick();
        total++; if (bus.s_axis_tready !== 4'b0100) begin bad++; $display("FAIL carry_ready: got %b want 0100", bus.s_axis_tready); end
        tick();
        drive_port(2, 1'b0, 0, 0, 1'b0);
        #1;
        total++; if (bus.m_axis_tdata !== 5'b11110) begin bad++; $display("FAIL carry_data: got %0d want 30", bus.m_axis_tdata); end
        total++; if (bus.m_axis_tid !== 2'd2) begin bad++; $display("FAIL carry_tid: got %0d want 2", bus.m_axis_tid); end
        tick();
    endtask

    task automatic test_fairness();
        rst = 1'b1;
        model_reset();
        #1;
        rst = 1'b0;
        drv_mready = 1'b1;
        for (int p = 0; p < P; p++) drive_port(p, 1'b1, p, p + 1, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            tick();
            total++; if (bus.m_axis_tvalid !== ((k % 2) == 0)) begin bad++; $display("FAIL fair_valid_%0d: got %0b want %0b", k, bus.m_axis_tvalid, (k % 2) == 0); end
            if ((k % 2) == 0) begin
                total++; if (int'(bus.m_axis_tid) != ((k / 2) - 1) % P) begin bad++; $display("FAIL fair_tid_%0d: got %0d want %0d", k, bus.m_axis_tid, ((k / 2) - 1) % P); end
                total++; if (int'(bus.m_axis_tdata) != 2 * (((k / 2) - 1) % P) + 1) begin bad++; $display("FAIL fair_data_%0d: got %0d want %0d", k, bus.m_axis_tdata, 2 * (((k / 2) - 1) % P) + 1); end
            end
        end
        drv_valid = '0;
        drv_last  = '0;
        tick();
    endtask

    task automatic test_packet_lock();
        drive_port(1, 1'b1, 1, 1, 1'b0);
        tick();
        drive_port(0, 1'b1, 9, 0, 1'b1);
        #1;
        total++; if (bus.s_axis_tready !== 4'b0010) begin bad++; $display("FAIL lock_ready1: got %b want 0010", bus.s_axis_tready); end
        tick();
        drive_port(1, 1'b1, 2, 2, 1'b0);
        #1;
        total++; if (bus.m_axis_tdata !== 5'd2 || bus.m_axis_tid !== 2'd1 || bus.m_axis_tlast !== 1'b0) begin bad++; $display("FAIL lock_beat1: got d=%0d id=%0d l=%0b want d=2 id=1 l=0", bus.m_axis_tdata, bus.m_axis_tid, bus.m_axis_tlast); end
        tick();
        drive_port(1, 1'b1, 3, 3, 1'b1);
        #1;
        total++; if (bus.m_axis_tdata !== 5'd4 || bus.m_axis_tid !== 2'd1 || bus.m_axis_tlast !== 1'b0) begin bad++; $display("FAIL lock_beat2: got d=%0d id=%0d l=%0b want d=4 id=1 l=0", bus.m_axis_tdata, bus.m_axis_tid, bus.m_axis_tlast); end
        total++; if (bus.s_axis_tready !== 4'b0010) begin bad++; $display("FAIL lock_ready2: got %b want 0010", bus.s_axis_tready); end
        tick();
        drive_port(1, 1'b0, 0, 0, 1'b0);
        #1;
        total++; if (bus.m_axis_tdata !== 5'd6 || bus.m_axis_tid !== 2'd1 || bus.m_axis_tlast !== 1'b1) begin bad++; $display("FAIL lock_beat3: got d=%0d id=%0d l=%0b want d=6 id=1 l=1", bus.m_axis_tdata, bus.m_axis_tid, bus.m_axis_tlast); end
        total++; if (bus.s_axis_tready !== 4'b0000) begin bad++; $display("FAIL lock_gap_ready: got %b want 0000", bus.s_axis_tready); end
        tick();
        total++; if (bus.s_axis_tready !== 4'b0001) begin bad++; $display("FAIL lock_next_ready: got %b want 0001", bus.s_axis_tready); end
        tick();
        drive_port(0, 1'b0, 0, 0, 1'b0);
        #1;
        total++; if (bus.m_axis_tdata !== 5'd9 || bus.m_axis_tid !== 2'd0) begin bad++; $display("FAIL lock_port0: got d=%0d id=%0d want d=9 id=0", bus.m_axis_tdata, bus.m_axis_tid); end
        tick();
    endtask

    task automatic test_backpressure();
        int bi;
        int got_d[$];
        int got_id[$];
        int got_l[$];
        bit acc;
        bi = 0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            drv_mready = !(cyc >= 4 && cyc < 9);
            drive_port(3, bi < 4, bi + 1, bi + 1, bi == 3);
            #1;
            total++; if (bus.m_axis_tvalid !== mo_ov) begin bad++; $display("FAIL bp_valid_%0d: got %0b want %0b", cyc, bus.m_axis_tvalid, mo_ov); end
            if (mo_ov) begin
                total++; if (int'(bus.m_axis_tdata) != mo_od) begin bad++; $display("FAIL bp_hold_%0d: got %0d want %0d", cyc, bus.m_axis_tdata, mo_od); end
            end
            if (mo_ov && !drv_mready) begin
                total++; if (bus.s_axis_tready !== 4'b0000) begin bad++; $display("FAIL bp_ready_%0d: got %b want 0000", cyc, bus.s_axis_tready); end
            end
            if (bus.m_axis_tvalid && drv_mready) begin
                got_d.push_back(int'(bus.m_axis_tdata));
                got_id.push_back(int'(bus.m_axis_tid));
                got_l.push_back(int'(bus.m_axis_tlast));
            end
            acc = model_ready()[3] && drv_valid[3];
            tick();
            if (acc) bi++;
        end
        drive_port(3, 1'b0, 0, 0, 1'b0);
        total++; if (got_d.size() != 4) begin bad++; $display("FAIL bp_count: got %0d want 4", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < 4; i++) begin
            total++; if (got_d[i] != 2 * (i + 1) || got_id[i] != 3 || got_l[i] != int'(i == 3)) begin bad++; $display("FAIL bp_beat_%0d: got d=%0d id=%0d l=%0d want d=%0d id=3 l=%0d", i, got_d[i], got_id[i], got_l[i], 2 * (i + 1), int'(i == 3)); end
        end
    endtask

    task automatic test_reset_mid();
        drv_mready = 1'b1;
        drive_port(2, 1'b1, 1, 2, 1'b0);
        tick();
        tick();
        drive_port(2, 1'b1, 2, 3, 1'b0);
        tick();
        total++; if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== 5'd5) begin bad++; $display("FAIL rmid_pre: got v=%0b d=%0d want v=1 d=5", bus.m_axis_tvalid, bus.m_axis_tdata); end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        total++; if (bus.m_axis_tvalid !== 1'b0 || bus.m_axis_tdata !== 5'd0 || bus.m_axis_tid !== 2'd0 || bus.m_axis_tlast !== 1'b0) begin bad++; $display("FAIL rmid_out: got v=%0b d=%0d id=%0d l=%0b want all 0", bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tid, bus.m_axis_tlast); end
        total++; if (bus.s_axis_tready !== 4'b0000 || bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_ctl: got rdy=%b busy=%0b want 0000/0", bus.s_axis_tready, bus.busy); end
        tick();
        rst = 1'b0;
        drive_port(0, 1'b1, 4, 4, 1'b1);
        #1;
        total++; if (bus.s_axis_tready !== 4'b0000) begin bad++; $display("FAIL rmid_idle: got %b want 0000", bus.s_axis_tready); end
        tick();
        total++; if (bus.s_axis_tready !== 4'b0001) begin bad++; $display("FAIL rmid_port0: got %b want 0001", bus.s_axis_tready); end
        tick();
        drive_port(0, 1'b0, 0, 0, 1'b0);
        drive_port(2, 1'b0, 0, 0, 1'b0);
        #1;
        total++; if (bus.m_axis_tdata !== 5'd8 || bus.m_axis_tid !== 2'd0) begin bad++; $display("FAIL rmid_result: got d=%0d id=%0d want d=8 id=0", bus.m_axis_tdata, bus.m_axis_tid); end
        tick();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int p = 0; p < P; p++) begin
                drv_valid[p] = ($urandom % 4) != 0;
                drv_a[p]     = W'($urandom);
                drv_b[p]     = W'($urandom);
                drv_last[p]  = ($urandom % 3) == 0;
            end
            drv_mready = ($urandom % 4) != 0;
            #1;
            total++; if (bus.s_axis_tready !== model_ready()) begin bad++; $display("FAIL rnd_ready_%0d: got %b want %b", cyc, bus.s_axis_tready, model_ready()); end
            total++; if (bus.busy !== (mo_owner >= 0)) begin bad++; $display("FAIL rnd_busy_%0d: got %0b want %0b", cyc, bus.busy, mo_owner >= 0); end
            total++; if (bus.m_axis_tvalid !== mo_ov) begin bad++; $display("FAIL rnd_valid_%0d: got %0b want %0b", cyc, bus.m_axis_tvalid, mo_ov); end
            if (mo_ov) begin
                total++; if (bus.m_axis_tdata !== 5'(mo_od) || bus.m_axis_tid !== 2'(mo_oid) || bus.m_axis_tlast !== 1'(mo_ol)) begin bad++; $display("FAIL rnd_beat_%0d: got d=%0d id=%0d l=%0b want d=%0d id=%0d l=%0d", cyc, bus.m_axis_tdata, bus.m_axis_tid, bus.m_axis_tlast, mo_od, mo_oid, mo_ol); end
            end
            tick();
        end
        drv_valid = '0;
        drv_mready = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        for (int p = 0; p < P; p++) begin
            drv_a[p] = '0;
            drv_b[p] = '0;
        end
        model_reset();
        test_reset();
        test_single_beat();
        test_carry();
        test_fairness();
        test_packet_lock();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
